// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;

   localparam int AW = 8;
   localparam int DW = 16;

   // The low byte of a word at the last address would fall off the memory end.
   localparam logic [AW-1:0] ADDR_LAST = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker with a last-grant pointer register.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       take,
   output logic       win,
   output logic       valid
);

   logic last;

   // A sole requester always wins; on contention the port not granted last time wins.
   assign valid = |req;
   assign win   = (req == 2'b11) ? ~last : req[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= 1'b1;
      end else if (take) begin
         last <= win;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared 256-byte data memory.
//
//   state | meaning
//   IDLE  | waiting for a request; winner and command registered on exit
//   CMD   | memory strobe + gnt for the winner (err instead of strobe at ADDR_LAST)
//   WAIT  | read only: memory data_out valid, captured into rdata
//   RESP  | read only: rvalid for the winner, rdata held
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          MemRead,
   output logic          MemWrite,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   input  logic [DW-1:0] data_out
);

   state_t        state, state_nxt;
   logic          win, any_req, take;
   logic          cmd_port, cmd_we, cmd_err;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .req   ({req1, req0}),
      .take  (take),
      .win   (win),
      .valid (any_req)
   );

   assign take = (state == IDLE) && any_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_port  <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_err   <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (take) begin
         cmd_port  <= win;
         cmd_we    <= win ? we1 : we0;
         cmd_addr  <= win ? addr1 : addr0;
         cmd_wdata <= win ? wdata1 : wdata0;
         cmd_err   <= (win ? addr1 : addr0) == ADDR_LAST;
      end
   end

   // A rejected read still completes, but returns zero instead of memory contents.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (state == WAIT) begin
         rdata <= cmd_err ? '0 : data_out;
      end
   end

   always_comb begin
      state_nxt = state;
      gnt0      = 1'b0;
      gnt1      = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
      err       = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) state_nxt = CMD;
         end
         CMD: begin
            gnt0      = ~cmd_port;
            gnt1      = cmd_port;
            err       = cmd_err;
            MemRead   = ~cmd_we & ~cmd_err;
            MemWrite  = cmd_we & ~cmd_err;
            state_nxt = cmd_we ? IDLE : WAIT;
         end
         WAIT: begin
            state_nxt = RESP;
         end
         RESP: begin
            rvalid0   = ~cmd_port;
            rvalid1   = cmd_port;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign addr_in = cmd_addr;
   assign data_in = cmd_wdata;

endmodule
